dcache_sram_sched: RTL and testbench

Scheduler and sequencer for the shared data/tag/valid-dirty SRAM arrays of the non-blocking L1 data cache. It sits between the requesters (miss handler, PTW, load unit, store unit) and the SRAM banks. It grants one requester per cycle with fixed priority plus anti-starvation aging, and routes the read response one cycle later. After reset, and on request, it sweeps every index to clear all valid/dirty bits before any requester is served. Data/tag/byte-enable muxing stays in the datapath; this block only drives SRAM control and select indices.

---
 rtl/dcache_sram_sched_pkg.sv | 19 +
 rtl/dcache_sram_sched_age_prio_arb.sv | 29 ++
 rtl/dcache_sram_sched.sv | 138 +++++++++++++
 tb/tb_dcache_sram_sched.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_sram_sched_pkg.sv
// Shared definitions for the L1 data cache SRAM scheduler: sequencer states,
// default array geometry and the index-width helper.
package dcache_sram_sched_pkg;

    localparam int unsigned NUM_WORDS_DEF = 256;
    localparam int unsigned AGE_MAX_DEF   = 15;

    function automatic int unsigned index_w(input int unsigned num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWEEP = 2'd3
    } state_e;

endpackage

// File: rtl/dcache_sram_sched_age_prio_arb.sv
// Combinational fixed-priority arbiter with age promotion: any aged requester
// beats every non-aged one, and ties resolve toward the lowest index.
module age_prio_arb #(
    parameter  int unsigned NR_PORTS = 4,
    localparam int unsigned PORT_W   = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic [NR_PORTS-1:0] req_i,
    input  logic [NR_PORTS-1:0] aged_i,
    output logic [NR_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]   idx_o
);

    logic [NR_PORTS-1:0] pick;

    always_comb begin
        pick  = (|(req_i & aged_i)) ? (req_i & aged_i) : req_i;
        gnt_o = '0;
        idx_o = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int p = NR_PORTS - 1; p >= 0; p--) begin
            if (pick[p]) begin
                gnt_o    = '0;
                gnt_o[p] = 1'b1;
                idx_o    = PORT_W'(p);
            end
        end
    end

endmodule

// File: rtl/dcache_sram_sched.sv
// SRAM scheduler for the L1 data cache: per-cycle grant with aging, read
// response routing, and the valid/dirty clear sweep after reset or on flush.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | post-reset sweep clearing valid/dirty at every index
// ST_RUN   | arbitrate requesters, one SRAM access per cycle
// ST_DRAIN | one idle cycle so the last read response can complete
// ST_SWEEP | flush sweep, identical to INIT but acks instead of init_done
module dcache_sram_sched
    import dcache_sram_sched_pkg::*;
#(
    parameter  int unsigned NR_PORTS  = 4,
    parameter  int unsigned SET_ASSOC = 8,
    parameter  int unsigned NUM_WORDS = NUM_WORDS_DEF,
    parameter  int unsigned AGE_MAX   = AGE_MAX_DEF,
    localparam int unsigned INDEX_W   = index_w(NUM_WORDS),
    localparam int unsigned PORT_W    = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]  req_i,
    input  logic [NR_PORTS-1:0]                 we_i,
    input  logic [NR_PORTS-1:0][INDEX_W-1:0]    addr_i,
    output logic [NR_PORTS-1:0]                 gnt_o,
    output logic [PORT_W-1:0]                   sel_o,
    output logic [NR_PORTS-1:0]                 rvalid_o,
    output logic [PORT_W-1:0]                   rsel_o,
    output logic [SET_ASSOC-1:0]                req_ram_o,
    output logic                                we_ram_o,
    output logic [INDEX_W-1:0]                  addr_ram_o,
    output logic                                clr_o,
    input  logic                                flush_i,
    output logic                                flush_ack_o,
    output logic                                init_done_o
);

    localparam int unsigned       AGE_W    = $clog2(AGE_MAX + 1);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_WORDS - 1);

    state_e                           state_q, state_d;
    logic [INDEX_W-1:0]               cnt_q, cnt_d;
    logic [NR_PORTS-1:0][AGE_W-1:0]   age_q, age_d;
    logic                             init_done_q, init_done_d;
    logic [NR_PORTS-1:0]              rvalid_q;
    logic [PORT_W-1:0]                rsel_q;

    logic [NR_PORTS-1:0]              cand, aged, arb_req, arb_gnt;
    logic [PORT_W-1:0]                arb_idx;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            cand[p] = |req_i[p];
            aged[p] = (age_q[p] == AGE_W'(AGE_MAX));
        end
        arb_req = (state_q == ST_RUN) ? cand : '0;
    end

    age_prio_arb #(.NR_PORTS(NR_PORTS)) u_arb (
        .req_i  (arb_req),
        .aged_i (aged),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign gnt_o       = arb_gnt;
    assign sel_o       = arb_idx;
    assign rvalid_o    = rvalid_q;
    assign rsel_o      = rsel_q;
    assign init_done_o = init_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        req_ram_o   = '0;
        we_ram_o    = 1'b0;
        addr_ram_o  = '0;
        clr_o       = 1'b0;
        flush_ack_o = 1'b0;
        case (state_q)
            ST_INIT, ST_SWEEP: begin
                req_ram_o  = '1;
                we_ram_o   = 1'b1;
                clr_o      = 1'b1;
                addr_ram_o = cnt_q;
                cnt_d      = cnt_q + INDEX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    if (state_q == ST_INIT) init_done_d = 1'b1;
                    else                    flush_ack_o = 1'b1;
                end
            end
            ST_RUN: begin
                if (|arb_gnt) begin
                    req_ram_o  = req_i[arb_idx];
                    we_ram_o   = we_i[arb_idx];
                    addr_ram_o = addr_i[arb_idx];
                end
                // Grants this cycle still go out; the flush starts next cycle.
                if (flush_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            if (!cand[p] || arb_gnt[p]) age_d[p] = '0;
            else if (!aged[p])          age_d[p] = age_q[p] + AGE_W'(1);
            else                        age_d[p] = age_q[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            age_q       <= '0;
            init_done_q <= 1'b0;
            rvalid_q    <= '0;
            rsel_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            init_done_q <= init_done_d;
            rvalid_q    <= arb_gnt & ~we_i;
            rsel_q      <= arb_idx;
        end
    end

endmodule

// File: tb/tb_dcache_sram_sched.sv
// Self-checking bench for dcache_sram_sched: directed scenarios plus a
// randomized run scored against a behavioural arbitration/aging model.
module tb_dcache_sram_sched;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0][7:0] req;
    logic [3:0]      we;
    logic [3:0][7:0] addr;
    logic            flush;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic [3:0]      rvalid;
    logic [1:0]      rsel;
    logic [7:0]      req_ram;
    logic            we_ram;
    logic [7:0]      addr_ram;
    logic            clr;
    logic            flush_ack;
    logic            init_done;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dcache_sram_sched dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .gnt_o       (gnt),
        .sel_o       (sel),
        .rvalid_o    (rvalid),
        .rsel_o      (rsel),
        .req_ram_o   (req_ram),
        .we_ram_o    (we_ram),
        .addr_ram_o  (addr_ram),
        .clr_o       (clr),
        .flush_i     (flush),
        .flush_ack_o (flush_ack),
        .init_done_o (init_done)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req   = '0;
        we    = '0;
        addr  = '0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        n_checks++;
        if ({gnt, sel, rvalid, rsel, flush_ack, init_done} !== 14'd0)
            $display("FAIL reset_outputs gnt=%b sel=%0d rvalid=%b rsel=%0d ack=%b done=%b want all 0",
                     gnt, sel, rvalid, rsel, flush_ack, init_done);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_init_sweep();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n_checks++;
            if (addr_ram !== 8'(i) || we_ram !== 1'b1 || clr !== 1'b1 || gnt !== 4'b0 ||
                req_ram !== 8'hFF || init_done !== 1'b0)
                $display("FAIL init_sweep i=%0d addr=%0d we=%b clr=%b gnt=%b req_ram=%h done=%b",
                         i, addr_ram, we_ram, clr, gnt, req_ram, init_done);
            else n_pass++;
            next_cycle();
        end
        @(negedge clk);
        n_checks++;
        if (init_done !== 1'b1 || clr !== 1'b0 || we_ram !== 1'b0)
            $display("FAIL init_done got done=%b clr=%b we=%b want 1,0,0", init_done, clr, we_ram);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_fixed_prio();
        idle();
        req[0] = 8'h01; addr[0] = 8'h10;
        req[2] = 8'h0F; addr[2] = 8'h20;
        req[3] = 8'hF0; addr[3] = 8'h30;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || req_ram !== 8'h01 || addr_ram !== 8'h10 || we_ram !== 1'b0)
            $display("FAIL fixed_prio gnt=%b sel=%0d req_ram=%h addr=%h we=%b want 0001,0,01,10,0",
                     gnt, sel, req_ram, addr_ram, we_ram);
        else n_pass++;
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0001 || rsel !== 2'd0 || gnt !== 4'b0)
            $display("FAIL fixed_prio_resp rvalid=%b rsel=%0d gnt=%b want 0001,0,0000", rvalid, rsel, gnt);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_aging();
        logic [3:0] exp_gnt;
        idle();
        req[0] = 8'h01;
        req[3] = 8'h80; addr[3] = 8'h44;
        for (int k = 0; k < 17; k++) begin
            exp_gnt = (k == 15) ? 4'b1000 : 4'b0001;
            @(negedge clk);
            n_checks++;
            if (gnt !== exp_gnt || sel !== ((k == 15) ? 2'd3 : 2'd0))
                $display("FAIL aging k=%0d gnt=%b sel=%0d want %b", k, gnt, sel, exp_gnt);
            else n_pass++;
            if (k == 16) begin
                n_checks++;
                if (rvalid !== 4'b1000 || rsel !== 2'd3)
                    $display("FAIL aging_resp rvalid=%b rsel=%0d want 1000,3", rvalid, rsel);
                else n_pass++;
            end
            next_cycle();
        end
        idle();
        next_cycle();
    endtask

    task automatic test_write();
        idle();
        req[3] = 8'h3C; we[3] = 1'b1; addr[3] = 8'h2A;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b1000 || we_ram !== 1'b1 || addr_ram !== 8'h2A || req_ram !== 8'h3C)
            $display("FAIL write gnt=%b we=%b addr=%h req_ram=%h want 1000,1,2a,3c",
                     gnt, we_ram, addr_ram, req_ram);
        else n_pass++;
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0)
            $display("FAIL write_no_rvalid rvalid=%b want 0000", rvalid);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_random();
        int         age [4];
        bit         pend [4];
        int         w;
        logic [3:0] exp_gnt;
        logic [3:0] exp_rv;
        logic [1:0] exp_rsel;
        logic [7:0] exp_rr, exp_ad;
        logic       exp_we;
        for (int p = 0; p < 4; p++) begin age[p] = 0; pend[p] = 0; end
        exp_rv = '0; exp_rsel = '0;
        idle();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(99) < ((p == 0) ? 85 : 40)) begin
                        pend[p] = 1;
                        req[p]  = 8'($urandom_range(1, 255));
                        we[p]   = 1'($urandom_range(1));
                        addr[p] = 8'($urandom_range(255));
                    end else begin
                        req[p] = '0; we[p] = 1'b0; addr[p] = '0;
                    end
                end
            end
            w = -1;
            for (int p = 0; p < 4; p++) if (w < 0 && pend[p] && age[p] == 15) w = p;
            for (int p = 0; p < 4; p++) if (w < 0 && pend[p]) w = p;
            exp_gnt = (w < 0) ? 4'b0 : 4'(1 << w);
            exp_rr  = (w < 0) ? 8'h0 : req[w];
            exp_ad  = (w < 0) ? 8'h0 : addr[w];
            exp_we  = (w < 0) ? 1'b0 : we[w];
            @(negedge clk);
            n_checks++;
            if (gnt !== exp_gnt || sel !== ((w < 0) ? 2'd0 : 2'(w)))
                $display("FAIL rand_grant cyc=%0d gnt=%b sel=%0d want %b", cyc, gnt, sel, exp_gnt);
            else n_pass++;
            n_checks++;
            if (req_ram !== exp_rr || addr_ram !== exp_ad || we_ram !== exp_we || clr !== 1'b0)
                $display("FAIL rand_sram cyc=%0d req_ram=%h addr=%h we=%b clr=%b want %h,%h,%b,0",
                         cyc, req_ram, addr_ram, we_ram, clr, exp_rr, exp_ad, exp_we);
            else n_pass++;
            n_checks++;
            if (rvalid !== exp_rv || rsel !== exp_rsel)
                $display("FAIL rand_resp cyc=%0d rvalid=%b rsel=%0d want %b,%0d",
                         cyc, rvalid, rsel, exp_rv, exp_rsel);
            else n_pass++;
            for (int p = 0; p < 4; p++) begin
                if (!pend[p] || p == w) age[p] = 0;
                else if (age[p] < 15)   age[p] = age[p] + 1;
            end
            exp_rv   = (w >= 0 && !exp_we) ? exp_gnt : 4'b0;
            exp_rsel = (w < 0) ? 2'd0 : 2'(w);
            if (w >= 0) pend[w] = 0;
            next_cycle();
        end
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== exp_rv || rsel !== exp_rsel)
            $display("FAIL rand_tail rvalid=%b rsel=%0d want %b,%0d", rvalid, rsel, exp_rv, exp_rsel);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_flush();
        idle();
        req[1] = 8'h02; addr[1] = 8'h11; flush = 1'b1;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0010 || addr_ram !== 8'h11 || flush_ack !== 1'b0)
            $display("FAIL flush_same_cycle gnt=%b addr=%h ack=%b want 0010,11,0", gnt, addr_ram, flush_ack);
        else n_pass++;
        next_cycle();
        req[1] = '0; addr[1] = '0;
        req[2] = 8'h04; addr[2] = 8'h33;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0010 || rsel !== 2'd1 || gnt !== 4'b0 || req_ram !== 8'h0 || clr !== 1'b0)
            $display("FAIL flush_drain rvalid=%b rsel=%0d gnt=%b req_ram=%h clr=%b want 0010,1,0,00,0",
                     rvalid, rsel, gnt, req_ram, clr);
        else n_pass++;
        next_cycle();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            n_checks++;
            if (addr_ram !== 8'(i) || clr !== 1'b1 || we_ram !== 1'b1 || req_ram !== 8'hFF ||
                gnt !== 4'b0 || flush_ack !== (i == 255))
                $display("FAIL flush_sweep i=%0d addr=%0d clr=%b gnt=%b ack=%b",
                         i, addr_ram, clr, gnt, flush_ack);
            else n_pass++;
            next_cycle();
        end
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0100 || flush_ack !== 1'b0 || clr !== 1'b0 || addr_ram !== 8'h33)
            $display("FAIL flush_resume gnt=%b ack=%b clr=%b addr=%h want 0100,0,0,33",
                     gnt, flush_ack, clr, addr_ram);
        else n_pass++;
        next_cycle();
        idle();
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0100 || rsel !== 2'd2 || gnt !== 4'b0 || clr !== 1'b0)
            $display("FAIL flush_after rvalid=%b rsel=%0d gnt=%b clr=%b want 0100,2,0,0",
                     rvalid, rsel, gnt, clr);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid_sweep();
        idle();
        flush = 1'b1;
        next_cycle();
        next_cycle();
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            n_checks++;
            if (addr_ram !== 8'(i) || clr !== 1'b1 || flush_ack !== 1'b0)
                $display("FAIL pre_reset_sweep i=%0d addr=%0d clr=%b ack=%b", i, addr_ram, clr, flush_ack);
            else n_pass++;
            if (i == 100) rst = 1'b1;
            next_cycle();
        end
        rst   = 1'b0;
        flush = 1'b0;
        for (int j = 0; j < 260; j++) begin
            @(negedge clk);
            n_checks++;
            if (j < 256) begin
                if (addr_ram !== 8'(j) || clr !== 1'b1 || init_done !== 1'b0 || flush_ack !== 1'b0)
                    $display("FAIL reinit j=%0d addr=%0d clr=%b done=%b ack=%b",
                             j, addr_ram, clr, init_done, flush_ack);
                else n_pass++;
            end else begin
                if (init_done !== 1'b1 || clr !== 1'b0 || flush_ack !== 1'b0)
                    $display("FAIL reinit_done j=%0d done=%b clr=%b ack=%b want 1,0,0",
                             j, init_done, clr, flush_ack);
                else n_pass++;
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_init_sweep();
        test_fixed_prio();
        test_aging();
        test_write();
        test_random();
        test_flush();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
